// File: rtl/bus_uart_if.sv
// Purpose: CPU-side bus bundle for the memory-mapped UART.
// Signals:
//   i_addr  [15:0]  CPU address
//   i_wdata [7:0]   CPU write data
//   i_wr            write strobe, one cycle per access
//   i_rd            read strobe, one cycle per access (read side effects)
//   o_sel           address hits DATA or STATUS (combinational)
//   o_rdata [7:0]   read data for i_addr (combinational), 0 when not selected
interface bus_uart_if;
  logic [15:0] i_addr;
  logic [7:0]  i_wdata;
  logic        i_wr;
  logic        i_rd;
  logic        o_sel;
  logic [7:0]  o_rdata;

  modport master (
    output i_addr, i_wdata, i_wr, i_rd,
    input  o_sel, o_rdata
  );

  modport slave (
    input  i_addr, i_wdata, i_wr, i_rd,
    output o_sel, o_rdata
  );
endinterface

// File: rtl/bus_uart.sv
// Purpose: memory-mapped 8N1 UART on the 8-bit CPU bus.
//   DATA   (BASE_ADDR)   : write queues a TX byte, read pops the RX FIFO head.
//   STATUS (BASE_ADDR+1) : {4'b0, ferr, ovr, tx_ready, rx_avail}; read clears ferr/ovr.
// Ports:
//   clock_25  bus/UART clock
//   reset_n   asynchronous active-low reset
//   bus       CPU bus bundle (slave side)
//   uart_rx   asynchronous serial input
//   uart_tx   serial output, idles high
module bus_uart #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int unsigned DIV       = 217,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic       clock_25,
  input  logic       reset_n,
  bus_uart_if.slave  bus,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned PW  = $clog2(RX_DEPTH);
  localparam int unsigned PW1 = PW + 1;

  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  // TX state
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    hold_byte_q, hold_byte_d;

  // RX state
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;

  // RX FIFO and sticky flags
  logic [7:0]    mem_q [RX_DEPTH];
  logic [7:0]    mem_d [RX_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  // Combinational helpers
  logic          sel_data_c, sel_stat_c;
  logic          fifo_empty_c, fifo_full_c;
  logic [7:0]    head_c, status_c;
  logic          pop_c, stat_clr_c, push_ok_c, ovr_set_c;
  logic          tx_take_c, wr_ok_c;
  logic          rx_push_c, rx_ferr_c;

  // Address decode and read mux
  always_comb begin
    sel_data_c   = (bus.i_addr == BASE_ADDR);
    sel_stat_c   = (bus.i_addr == STAT_ADDR);
    fifo_empty_c = (rd_ptr_q == wr_ptr_q);
    fifo_full_c  = (rd_ptr_q[PW] != wr_ptr_q[PW]) &&
                   (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
    head_c       = fifo_empty_c ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];
    status_c     = {4'b0000, ferr_q, ovr_q, ~hold_full_q, ~fifo_empty_c};
  end

  assign bus.o_sel   = sel_data_c | sel_stat_c;
  assign bus.o_rdata = sel_data_c ? head_c : (sel_stat_c ? status_c : 8'h00);
  assign uart_tx     = tx_q;

  // TX FSM; holding register may be refilled the same cycle it is drained
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    tx_take_c   = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        if (hold_full_q) begin
          tx_take_c  = 1'b1;
          tx_shift_d = hold_byte_q;
          tx_cnt_d   = DIV_M1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          // Queued byte follows immediately with no idle bit
          if (hold_full_q) begin
            tx_take_c  = 1'b1;
            tx_shift_d = hold_byte_q;
            tx_cnt_d   = DIV_M1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    wr_ok_c = bus.i_wr && sel_data_c && (!hold_full_q || tx_take_c);
    if (tx_take_c) hold_full_d = 1'b0;
    if (wr_ok_c) begin
      hold_full_d = 1'b1;
      hold_byte_d = bus.i_wdata;
    end

    // Line level follows the state being entered so each state lasts DIV cycles on the wire
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // RX synchroniser and FSM
  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = HALF_M1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_push_c  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_c  = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_WAIT: begin
        // Hold off until the line returns high so a broken frame cannot retrigger
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO pointers, storage and sticky flags; a write strobe suppresses read side effects
  always_comb begin
    pop_c      = bus.i_rd && !bus.i_wr && sel_data_c && !fifo_empty_c;
    stat_clr_c = bus.i_rd && !bus.i_wr && sel_stat_c;
    push_ok_c  = rx_push_c && (!fifo_full_c || pop_c);
    ovr_set_c  = rx_push_c && fifo_full_c && !pop_c;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;

    if (push_ok_c) begin
      mem_d[wr_ptr_q[PW-1:0]] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + PW1'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PW1'(1);

    // A new event in the clearing cycle wins so it is never lost
    if (stat_clr_c) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovr_set_c) ovr_d  = 1'b1;
    if (rx_ferr_c) ferr_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      for (int unsigned i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Testbench for bus_uart: random TX/RX bytes checked against a queue-based model
// of the register map, plus serial-line timing checks on uart_tx.
module tb_bus_uart;

  localparam int unsigned DIV      = 217;
  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned FRAME    = 10 * DIV;
  localparam logic [15:0] A_DATA   = 16'hC000;
  localparam logic [15:0] A_STAT   = 16'hC001;

  logic clock_25;
  logic reset_n;
  logic uart_rx;
  logic uart_tx;
  int   cyc;
  int   n_tests;
  int   n_fail;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ovr;
  bit         m_ferr;
  bit         m_tx_ready;

  bus_uart_if bif ();

  bus_uart #(
    .BASE_ADDR (16'hC000),
    .DIV       (DIV),
    .RX_DEPTH  (RX_DEPTH)
  ) dut (
    .clock_25 (clock_25),
    .reset_n  (reset_n),
    .bus      (bif.slave),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  initial clock_25 = 1'b0;
  always #20 clock_25 = ~clock_25;
  always @(posedge clock_25) cyc <= cyc + 1;

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {4'b0000, m_ferr, m_ovr, m_tx_ready, (m_q.size() != 0)};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock_25);
    bif.i_addr = a; bif.i_wdata = d; bif.i_wr = 1'b1; bif.i_rd = 1'b0;
    @(posedge clock_25); #1;
    bif.i_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock_25);
    bif.i_addr = a; bif.i_rd = 1'b1; bif.i_wr = 1'b0;
    #1 d = bif.o_rdata;
    @(posedge clock_25); #1;
    bif.i_rd = 1'b0;
  endtask

  task automatic bus_rdwr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock_25);
    bif.i_addr = a; bif.i_wdata = d; bif.i_rd = 1'b1; bif.i_wr = 1'b1;
    @(posedge clock_25); #1;
    bif.i_rd = 1'b0; bif.i_wr = 1'b0;
  endtask

  // Read DATA and compare against the model FIFO head
  task automatic read_data(input string tag);
    logic [7:0] v, e;
    e = (m_q.size() != 0) ? m_q.pop_front() : 8'h00;
    bus_read(A_DATA, v);
    check(tag, v, e);
  endtask

  // Read STATUS (pre-clear value) then clear sticky flags in the model
  task automatic read_status(input string tag);
    logic [7:0] v, e;
    e = model_status();
    bus_read(A_STAT, v);
    check(tag, v, e);
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Serialise one frame onto uart_rx and update the model with its outcome
  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(negedge clock_25);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clock_25);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (DIV) @(negedge clock_25);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clock_25);
    uart_rx = 1'b1;
    repeat (6) @(negedge clock_25);
    if (stop) begin
      if (m_q.size() < RX_DEPTH) m_q.push_back(b);
      else                       m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // Wait (bounded) for a start bit on uart_tx and record the whole frame
  task automatic tx_frame(input int timeout, output bit ok, output logic [7:0] b,
                          output int start, output int low_len,
                          output logic start_mid, output logic stop_mid);
    bit line [FRAME];
    ok = 1'b0; b = 8'h00; start = 0; low_len = 0; start_mid = 1'b1; stop_mid = 1'b0;
    for (int t = 0; t < timeout; t++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock_25);
    end
    if (ok) begin
      start = cyc;
      for (int i = 0; i < FRAME; i++) begin
        line[i] = uart_tx;
        @(negedge clock_25);
      end
      while (low_len < FRAME && line[low_len] == 1'b0) low_len++;
      for (int k = 0; k < 8; k++) b[k] = line[(k + 1) * DIV + DIV / 2];
      start_mid = line[DIV / 2];
      stop_mid  = line[9 * DIV + DIV / 2];
    end
  endtask

  initial begin
    logic [7:0] v, b1, b2, b3, fb1, fb2;
    bit         ok1, ok2;
    int         s1, s2, ll1, ll2;
    logic       sm1, sp1, sm2, sp2;

    n_tests = 0; n_fail = 0; cyc = 0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_tx_ready = 1'b1;
    uart_rx = 1'b1;
    bif.i_addr = 16'h0000; bif.i_wdata = 8'h00; bif.i_wr = 1'b0; bif.i_rd = 1'b0;
    reset_n = 1'b0;
    repeat (5) @(negedge clock_25);
    reset_n = 1'b1;
    repeat (3) @(negedge clock_25);

    // Reset state and address decode
    check("reset_tx", uart_tx, 1'b1);
    read_status("reset_status");
    read_data("reset_data_empty");
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 16'hBFFF));
      @(negedge clock_25);
      bif.i_addr = a;
      #1;
      check("sel_miss", bif.o_sel, 1'b0);
      check("rdata_miss", bif.o_rdata, 8'h00);
    end
    @(negedge clock_25);
    bif.i_addr = A_STAT;
    #1 check("sel_stat", bif.o_sel, 1'b1);

    // T1: A5 frame timing and bit order
    fork
      bus_write(A_DATA, 8'hA5);
      tx_frame(50, ok1, fb1, s1, ll1, sm1, sp1);
    join
    check("t1_started", ok1, 1'b1);
    check("t1_start_len", ll1, DIV);
    check("t1_byte", fb1, 8'hA5);
    check("t1_stop", sp1, 1'b1);
    check("t1_idle_after", uart_tx, 1'b1);
    read_status("t1_status");

    // T2: back-to-back writes, contiguous frames, third write dropped
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    fork
      begin
        bus_write(A_DATA, b1);
        bus_write(A_DATA, b2);
        m_tx_ready = 1'b0;
        read_status("t2_tx_busy");
        bus_write(A_DATA, b3);
      end
      begin
        tx_frame(50, ok1, fb1, s1, ll1, sm1, sp1);
        tx_frame(50, ok2, fb2, s2, ll2, sm2, sp2);
      end
    join
    m_tx_ready = 1'b1;
    check("t2_ok", {ok1, ok2}, 2'b11);
    check("t2_byte1", fb1, b1);
    check("t2_byte2", fb2, b2);
    check("t2_gap", s2 - s1, FRAME);
    check("t2_stop2", sp2, 1'b1);
    tx_frame(3 * DIV, ok1, fb1, s1, ll1, sm1, sp1);
    check("t2_third_dropped", ok1, 1'b0);

    // T3: single RX byte, then a few random ones read one at a time
    rx_send(8'h5A, 1'b1);
    read_status("t3_avail");
    read_data("t3_data");
    read_status("t3_empty");
    for (int i = 0; i < 3; i++) begin
      rx_send(8'($urandom), 1'b1);
      read_data("rx_rand");
    end

    // T4: overflow of the RX FIFO
    for (int i = 0; i < 5; i++) rx_send(8'($urandom), 1'b1);
    read_status("t4_ovr");
    for (int i = 0; i < 5; i++) read_data("t4_drain");
    read_status("t4_cleared");

    // T5: framing error, then a short glitch on the idle line
    rx_send(8'($urandom), 1'b0);
    read_status("t5_ferr");
    read_data("t5_no_byte");
    @(negedge clock_25);
    uart_rx = 1'b0;
    repeat (40) @(negedge clock_25);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clock_25);
    read_status("t5_glitch_status");
    read_data("t5_glitch_data");

    // Simultaneous read and write on DATA: write wins, no pop
    rx_send(8'($urandom), 1'b1);
    b1 = 8'($urandom);
    fork
      bus_rdwr(A_DATA, b1);
      tx_frame(50, ok1, fb1, s1, ll1, sm1, sp1);
    join
    check("rdwr_tx_ok", ok1, 1'b1);
    check("rdwr_tx_byte", fb1, b1);
    read_data("rdwr_no_pop");

    // T6: reset in the middle of a TX frame with a byte waiting in the RX FIFO
    rx_send(8'($urandom), 1'b1);
    bus_write(A_DATA, 8'($urandom));
    repeat (3 * DIV) @(negedge clock_25);
    bif.i_addr = A_STAT;
    reset_n = 1'b0;
    #1;
    check("t6_tx_in_reset", uart_tx, 1'b1);
    check("t6_status_in_reset", bif.o_rdata, 8'h02);
    m_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0; m_tx_ready = 1'b1;
    @(negedge clock_25);
    reset_n = 1'b1;
    read_status("t6_status");
    read_data("t6_fifo_cleared");
    tx_frame(2 * DIV, ok1, fb1, s1, ll1, sm1, sp1);
    check("t6_tx_quiet", ok1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
